melody_sequencer: RTL

- Upstream stage of the square-wave tone generator.
- Steps through a small melody table of {note, duration} entries. For each entry it drives the half-period count and the enable that the tone generator consumes.
- Sits between board controls (start/stop buttons, loop switch) and the audio output path.
- Note lengths are timed in beats derived from the system clock.

---
 rtl/melody_pkg.sv | 73 +++++++
 rtl/melody_rom.sv | 18 +
 rtl/melody_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note codes, FSM state encoding
// and the note-to-half-period table built from the system clock frequency.
package melody_pkg;

    // Note codes as stored in the upper nibble of a table entry
    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_E4   = 4'd5;
    localparam logic [3:0] NOTE_G4   = 4'd8;
    localparam logic [3:0] NOTE_A4   = 4'd10;
    localparam logic [3:0] NOTE_C5   = 4'd13;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_t;

    // Codes 0, 14 and 15 are silent
    function automatic logic is_rest(input logic [3:0] note);
        return (note == NOTE_REST) || (note >= 4'd14);
    endfunction

    // Pitch in millihertz; 0 for rests. C5 is 523.25 Hz to match the
    // reference table the tone generator was characterised against.
    function automatic longint note_mhz(input logic [3:0] note);
        longint f;
        case (note)
            4'd1:    f = 261_626;
            4'd2:    f = 277_183;
            4'd3:    f = 293_665;
            4'd4:    f = 311_127;
            4'd5:    f = 329_628;
            4'd6:    f = 349_228;
            4'd7:    f = 369_994;
            4'd8:    f = 391_995;
            4'd9:    f = 415_305;
            4'd10:   f = 440_000;
            4'd11:   f = 466_164;
            4'd12:   f = 493_883;
            4'd13:   f = 523_250;
            default: f = 0;
        endcase
        return f;
    endfunction

    // round(clk_hz / (2*f)); pitches under ~47.7 Hz would overflow 20 bits
    function automatic logic [19:0] note_half_period(input longint clk_hz, input logic [3:0] note);
        longint f;
        f = note_mhz(note);
        if (f == 0) begin
            return 20'd0;
        end
        return 20'((clk_hz * 1000 + f) / (2 * f));
    endfunction

    // All 16 half-periods packed, entry n at bits [20n +: 20]
    function automatic logic [319:0] half_period_table(input longint clk_hz);
        logic [319:0] t;
        t = '0;
        for (int n = 0; n < 16; n++) begin
            t[20*n +: 20] = note_half_period(clk_hz, 4'(n));
        end
        return t;
    endfunction

    // Power-on tune: C4 E4 G4 C5(2) rest G4 C5(2) end
    localparam logic [127:0] DEFAULT_SONG = 128'h0000_0000_0000_0000_00D2_8101_D281_5111;

endpackage

// File: rtl/melody_rom.sv
// Melody table: DEPTH entries of {note[3:0], dur[3:0]} with a registered
// read port (one cycle from address to data). Contents come from INIT,
// entry n at bits [8n +: 8].
module melody_rom #(
    parameter int DEPTH = 16,
    parameter logic [8*DEPTH-1:0] INIT = '0
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [7:0]               data
);

    // Registered table lookup
    always_ff @(posedge clk) begin
        data <= INIT[{addr, 3'b000} +: 8];
    end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks the melody table and drives the half-period and
// enable consumed by the square-wave tone generator. Each note plays for
// dur beats, followed by a short silent gap for articulation.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BEAT_TICKS = 25_000_000,
    parameter int GAP_TICKS  = 2_500_000,
    parameter int DEPTH      = 16,
    parameter logic [8*DEPTH-1:0] ROM_INIT = (8*DEPTH)'(DEFAULT_SONG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic [19:0]              half_period,
    output logic                     tone_en,
    output logic [$clog2(DEPTH)-1:0] note_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [319:0] HP_TABLE = half_period_table(longint'(CLK_HZ));

    state_t        state;
    logic [IW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [3:0]    rom_note;
    logic [3:0]    rom_dur;
    logic [PW-1:0] presc;
    logic [3:0]    beats;
    logic [GW-1:0] gap_cnt;
    logic          beat_wrap;
    logic          gap_last;
    logic          last_idx;

    assign rom_note  = rom_data[7:4];
    assign rom_dur   = rom_data[3:0];
    assign beat_wrap = (presc == PW'(BEAT_TICKS - 1));
    assign gap_last  = (gap_cnt == GW'(GAP_TICKS - 1));
    assign last_idx  = (note_idx == IW'(DEPTH - 1));

    // ROM address tracks the index note_idx will hold next cycle, so the
    // entry is already on rom_data during the FETCH cycle
    always_comb begin
        rom_addr = note_idx;
        case (state)
            ST_IDLE:  if (start) rom_addr = '0;
            ST_FETCH: if (rom_dur == 4'd0) rom_addr = '0;
            ST_GAP:   if (gap_last) rom_addr = note_idx + 1'b1;
            default:  rom_addr = note_idx;
        endcase
    end

    melody_rom #(
        .DEPTH (DEPTH),
        .INIT  (ROM_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // Sequencer FSM with registered outputs; stop overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            half_period <= '0;
            tone_en     <= 1'b0;
            note_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            presc       <= '0;
            beats       <= '0;
            gap_cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= ST_IDLE;
                tone_en <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state    <= ST_FETCH;
                            note_idx <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        if (rom_dur == 4'd0) begin
                            if (loop_en) begin
                                note_idx <= '0;
                            end else begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            state   <= ST_PLAY;
                            tone_en <= !is_rest(rom_note);
                            if (!is_rest(rom_note)) begin
                                half_period <= HP_TABLE[20*rom_note +: 20];
                            end
                            presc <= '0;
                            beats <= rom_dur;
                        end
                    end
                    ST_PLAY: begin
                        if (beat_wrap) begin
                            presc <= '0;
                            if (beats == 4'd1) begin
                                state   <= ST_GAP;
                                tone_en <= 1'b0;
                                gap_cnt <= '0;
                            end else begin
                                beats <= beats - 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_last) begin
                            if (last_idx && !loop_en) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                note_idx <= note_idx + 1'b1;
                                state    <= ST_FETCH;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state   <= ST_IDLE;
                        tone_en <= 1'b0;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        tone_en <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
